// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-line receiver: FSM state
// encoding, control character constants and the printable-byte test.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DROP    = 2'd2
    } uart_cmd_state_t;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;

    // Only visible ASCII (space through tilde) is stored in a line;
    // any other byte outside LF/CR/BS is silently ignored.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/uart_cmd_linebuf.sv
// Line storage: DEPTH x 8 array with one write port and one registered
// read port. The array itself is never reset; only the read register is.
module uart_cmd_linebuf #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    // Storage write, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read with one cycle of latency from rd_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command-line receiver: assembles bytes into LF-terminated lines,
// holds a completed line for a consumer until line_ack, drops overlong
// lines with ovf_pulse. Optional echo path: define UART_CMD_ECHO_EN.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rvld,
    input  logic [7:0]               rdata,
    output logic                     line_vld,
    output logic [$clog2(DEPTH):0]   line_len,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data,
    input  logic                     line_ack,
    output logic                     ovf_pulse,
`ifdef UART_CMD_ECHO_EN
    output logic [7:0]               echo_tdata,
    output logic                     echo_tvld,
    input  logic                     echo_trdy,
`endif
    output logic                     busy_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    uart_cmd_state_t r_state;
    logic [LW-1:0]   r_len;
    logic            r_line_vld;
    logic            r_ovf_pulse;
    logic            r_busy_drop;

    // A line_ack in HOLD takes effect before any byte in the same cycle, so
    // the byte is evaluated as if the FSM were already back in COLLECT.
    logic            w_ack;
    uart_cmd_state_t w_state_eff;
    logic [LW-1:0]   w_len_eff;
    logic            w_byte;
    logic            w_collect;
    logic            w_print;
    logic            w_room;
    logic            w_wr_en;

    assign w_ack       = (r_state == ST_HOLD) && line_ack;
    assign w_state_eff = w_ack ? ST_COLLECT : r_state;
    assign w_len_eff   = w_ack ? '0 : r_len;
    assign w_byte      = rvld && (rdata != CH_CR);
    assign w_collect   = w_byte && (w_state_eff == ST_COLLECT);
    assign w_print     = is_printable(rdata);
    assign w_room      = (w_len_eff < DEPTH_L);
    assign w_wr_en     = w_collect && w_print && w_room;

    // Line-assembly FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_COLLECT;
            r_len       <= '0;
            r_line_vld  <= 1'b0;
            r_ovf_pulse <= 1'b0;
            r_busy_drop <= 1'b0;
        end else begin
            r_ovf_pulse <= 1'b0;
            if (w_ack) begin
                r_state    <= ST_COLLECT;
                r_len      <= '0;
                r_line_vld <= 1'b0;
                r_busy_drop <= 1'b0;
            end
            if (w_byte) begin
                case (w_state_eff)
                    ST_COLLECT: begin
                        if (rdata == CH_LF) begin
                            r_state    <= ST_HOLD;
                            r_line_vld <= 1'b1;
                        end else if (rdata == CH_BS) begin
                            if (w_len_eff != '0) begin
                                r_len <= w_len_eff - LW'(1);
                            end
                        end else if (w_print) begin
                            if (w_room) begin
                                r_len <= w_len_eff + LW'(1);
                            end else begin
                                r_state <= ST_DROP;
                            end
                        end
                    end
                    ST_HOLD: begin
                        r_busy_drop <= 1'b1;
                    end
                    ST_DROP: begin
                        if (rdata == CH_LF) begin
                            r_ovf_pulse <= 1'b1;
                            r_len       <= '0;
                            r_state     <= ST_COLLECT;
                        end
                    end
                    default: begin
                        r_state <= ST_COLLECT;
                    end
                endcase
            end
        end
    end

    uart_cmd_linebuf #(
        .DEPTH (DEPTH)
    ) u_linebuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_addr (w_len_eff[AW-1:0]),
        .wr_data (rdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign line_vld  = r_line_vld;
    assign line_len  = r_len;
    assign ovf_pulse = r_ovf_pulse;
    assign busy_drop = r_busy_drop;

`ifdef UART_CMD_ECHO_EN
    logic       r_echo_full;
    logic [7:0] r_echo_buf;
    logic       r_echo_tvld;
    logic [7:0] r_echo_tdata;
    logic       w_echo_load;

    // Bytes accepted in COLLECT: stored printables, LF and BS.
    assign w_echo_load = w_collect && ((rdata == CH_LF) || (rdata == CH_BS) || w_wr_en);

    // One-entry echo register; a byte arriving while it stays full is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_echo_full  <= 1'b0;
            r_echo_buf   <= 8'h00;
            r_echo_tvld  <= 1'b0;
            r_echo_tdata <= 8'h00;
        end else begin
            r_echo_tvld <= 1'b0;
            if (r_echo_full && echo_trdy) begin
                r_echo_tvld  <= 1'b1;
                r_echo_tdata <= r_echo_buf;
                r_echo_full  <= 1'b0;
            end
            if (w_echo_load && (!r_echo_full || echo_trdy)) begin
                r_echo_full <= 1'b1;
                r_echo_buf  <= rdata;
            end
        end
    end

    assign echo_tvld  = r_echo_tvld;
    assign echo_tdata = r_echo_tdata;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed testbench for uart_cmd_rx (DEPTH=32). Define UART_CMD_ECHO_EN
// to also exercise the echo path.
module tb_uart_cmd_rx;

    localparam int DEPTH = 32;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rvld = 1'b0;
    logic [7:0]    rdata = 8'h00;
    logic          line_vld;
    logic [LW-1:0] line_len;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          line_ack = 1'b0;
    logic          ovf_pulse;
    logic          busy_drop;
`ifdef UART_CMD_ECHO_EN
    logic [7:0]    echo_tdata;
    logic          echo_tvld;
    logic          echo_trdy = 1'b0;
    logic [7:0]    echo_q[$];
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int ovf_cnt  = 0;

    always #5 clk = ~clk;

    uart_cmd_rx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rvld      (rvld),
        .rdata     (rdata),
        .line_vld  (line_vld),
        .line_len  (line_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .line_ack  (line_ack),
        .ovf_pulse (ovf_pulse),
`ifdef UART_CMD_ECHO_EN
        .echo_tdata(echo_tdata),
        .echo_tvld (echo_tvld),
        .echo_trdy (echo_trdy),
`endif
        .busy_drop (busy_drop)
    );

    // Pulse monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (ovf_pulse === 1'b1) ovf_cnt++;
`ifdef UART_CMD_ECHO_EN
        if (echo_tvld === 1'b1) echo_q.push_back(echo_tdata);
`endif
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rvld  = 1'b1;
        rdata = b;
        @(negedge clk);
        rvld  = 1'b0;
        rdata = 8'h00;
        $display("tx byte 0x%02h", b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
        $display("line_ack pulse");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (line_vld !== 1'b0 || line_len !== '0 || ovf_pulse !== 1'b0 ||
            busy_drop !== 1'b0 || rd_data !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_state: vld=%b len=%0d ovf=%b busy=%b rd=%02h, required 0 0 0 0 00",
                     line_vld, line_len, ovf_pulse, busy_drop, rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_help();
        logic [7:0] exp [4];
        exp[0] = 8'h68; exp[1] = 8'h65; exp[2] = 8'h6C; exp[3] = 8'h70;
        send_str("help\n");
        n_checks++;
        if (line_vld !== 1'b1 || line_len !== LW'(4)) begin
            n_fails++;
            $display("FAIL help_line: vld=%b len=%0d, required 1 4", line_vld, line_len);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            @(negedge clk);
            n_checks++;
            if (rd_data !== exp[i]) begin
                n_fails++;
                $display("FAIL help_data[%0d]: got %02h, required %02h", i, rd_data, exp[i]);
            end
        end
        pulse_ack();
        n_checks++;
        if (line_vld !== 1'b0 || line_len !== '0) begin
            n_fails++;
            $display("FAIL help_ack: vld=%b len=%0d, required 0 0", line_vld, line_len);
        end
    endtask

    task automatic test_overflow();
        ovf_cnt = 0;
        for (int i = 0; i < 33; i++) send_byte(8'h61);
        n_checks++;
        if (line_vld !== 1'b0) begin
            n_fails++;
            $display("FAIL ovf_no_line_before_lf: vld=%b, required 0", line_vld);
        end
        send_byte(8'h0A);
        repeat (2) @(negedge clk);
        n_checks++;
        if (ovf_cnt !== 1 || line_vld !== 1'b0 || line_len !== '0) begin
            n_fails++;
            $display("FAIL ovf_pulse: pulses=%0d vld=%b len=%0d, required 1 0 0",
                     ovf_cnt, line_vld, line_len);
        end
        send_str("led\n");
        n_checks++;
        if (line_vld !== 1'b1 || line_len !== LW'(3)) begin
            n_fails++;
            $display("FAIL ovf_next_line: vld=%b len=%0d, required 1 3", line_vld, line_len);
        end
        pulse_ack();
    endtask

    task automatic test_exact_full();
        ovf_cnt = 0;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h62);
        send_byte(8'h0A);
        n_checks++;
        if (line_vld !== 1'b1 || line_len !== LW'(DEPTH) || ovf_cnt !== 0) begin
            n_fails++;
            $display("FAIL full_line: vld=%b len=%0d ovf=%0d, required 1 32 0",
                     line_vld, line_len, ovf_cnt);
        end
        @(negedge clk);
        rd_addr = AW'(DEPTH - 1);
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h62) begin
            n_fails++;
            $display("FAIL full_last_byte: got %02h, required 62", rd_data);
        end
        pulse_ack();
    endtask

    task automatic test_backspace();
        send_str("ab");
        send_byte(8'h08);
        send_str("c\r\n");
        n_checks++;
        if (line_vld !== 1'b1 || line_len !== LW'(2)) begin
            n_fails++;
            $display("FAIL bs_line: vld=%b len=%0d, required 1 2", line_vld, line_len);
        end
        @(negedge clk); rd_addr = 0;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h61) begin
            n_fails++;
            $display("FAIL bs_data0: got %02h, required 61", rd_data);
        end
        rd_addr = 1;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h63) begin
            n_fails++;
            $display("FAIL bs_data1: got %02h, required 63", rd_data);
        end
        pulse_ack();
        // Backspace on an empty line has no effect; result is an empty line.
        send_byte(8'h08);
        send_byte(8'h0A);
        n_checks++;
        if (line_vld !== 1'b1 || line_len !== '0) begin
            n_fails++;
            $display("FAIL empty_line: vld=%b len=%0d, required 1 0", line_vld, line_len);
        end
        pulse_ack();
    endtask

    task automatic test_busy();
        send_str("ok\n");
        send_byte(8'h78);
        n_checks++;
        if (busy_drop !== 1'b1 || line_vld !== 1'b1 || line_len !== LW'(2)) begin
            n_fails++;
            $display("FAIL busy_drop: busy=%b vld=%b len=%0d, required 1 1 2",
                     busy_drop, line_vld, line_len);
        end
        @(negedge clk); rd_addr = 0;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h6F) begin
            n_fails++;
            $display("FAIL busy_data_kept: got %02h, required 6f", rd_data);
        end
        // Ack and a byte together: the byte starts the next line.
        @(negedge clk);
        line_ack = 1'b1; rvld = 1'b1; rdata = 8'h7A;
        @(negedge clk);
        line_ack = 1'b0; rvld = 1'b0; rdata = 8'h00;
        $display("line_ack with byte 0x7a");
        n_checks++;
        if (line_vld !== 1'b0 || busy_drop !== 1'b0 || line_len !== LW'(1)) begin
            n_fails++;
            $display("FAIL ack_with_byte: vld=%b busy=%b len=%0d, required 0 0 1",
                     line_vld, busy_drop, line_len);
        end
        // Ack outside HOLD is ignored.
        pulse_ack();
        n_checks++;
        if (line_len !== LW'(1)) begin
            n_fails++;
            $display("FAIL ack_outside_hold: len=%0d, required 1", line_len);
        end
        send_byte(8'h0A);
        @(negedge clk); rd_addr = 0;
        @(negedge clk);
        n_checks++;
        if (line_vld !== 1'b1 || line_len !== LW'(1) || rd_data !== 8'h7A) begin
            n_fails++;
            $display("FAIL z_line: vld=%b len=%0d rd=%02h, required 1 1 7a",
                     line_vld, line_len, rd_data);
        end
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        ovf_cnt = 0;
        send_str("le");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (line_vld !== 1'b0 || line_len !== '0) begin
            n_fails++;
            $display("FAIL reset_mid: vld=%b len=%0d, required 0 0", line_vld, line_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("mid-line reset");
        send_str("on\n");
        n_checks++;
        if (line_vld !== 1'b1 || line_len !== LW'(2) || ovf_cnt !== 0) begin
            n_fails++;
            $display("FAIL after_reset_line: vld=%b len=%0d ovf=%0d, required 1 2 0",
                     line_vld, line_len, ovf_cnt);
        end
        pulse_ack();
    endtask

`ifdef UART_CMD_ECHO_EN
    task automatic test_echo();
        logic [7:0] exp [3];
        exp[0] = 8'h68; exp[1] = 8'h69; exp[2] = 8'h0A;
        echo_trdy = 1'b1;
        repeat (2) @(negedge clk);
        echo_q.delete();
        send_str("hi\n");
        repeat (3) @(negedge clk);
        n_checks++;
        if (echo_q.size() != 3) begin
            n_fails++;
            $display("FAIL echo_count: got %0d, required 3", echo_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (echo_q[i] !== exp[i]) begin
                    n_fails++;
                    $display("FAIL echo_data[%0d]: got %02h, required %02h", i, echo_q[i], exp[i]);
                end
            end
        end
        pulse_ack();
    endtask
`endif

    initial begin
        test_reset();
        test_help();
        test_overflow();
        test_exact_full();
        test_backspace();
        test_busy();
        test_reset_mid();
`ifdef UART_CMD_ECHO_EN
        test_echo();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning maximum line length in bytes, excluding terminator; legal values are powers of two from 8 to 256.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port rvld, input, 1 bit: one-cycle strobe from the UART receiver; rdata is valid in that cycle.
REQ-005 SHALL have port rdata, input, 8 bits: received byte.
REQ-006 SHALL have port line_vld, output, 1 bit: a complete line is held for the consumer.
REQ-007 SHALL have port line_len, output, $clog2(DEPTH)+1 bits: byte count of the held line.
REQ-008 SHALL have port rd_addr, input, $clog2(DEPTH) bits: consumer read index.
REQ-009 SHALL have port rd_data, output, 8 bits: buffer[rd_addr], registered.
REQ-010 SHALL have port line_ack, input, 1 bit: one-cycle pulse; consumer releases the line.
REQ-011 SHALL have port ovf_pulse, output, 1 bit: one-cycle pulse; a line was discarded for overflow.
REQ-012 SHALL have port busy_drop, output, 1 bit: a byte arrived while a line was held and was discarded (sticky until line_ack).
REQ-013 SHALL have ports echo_tdata (output, 8 bits), echo_tvld (output, 1 bit) and echo_trdy (input, 1 bit); these are present only with UART_CMD_ECHO_EN.

Function
REQ-014 SHALL implement a 3-state FSM: COLLECT, HOLD, DROP.
- COLLECT + printable byte + len<DEPTH: write buffer[len], len++.
- COLLECT + byte 0x0A: go to HOLD; line_vld=1 on the next cycle.
- COLLECT + printable byte + len==DEPTH: go to DROP; buffer contents are discarded.
- DROP: ignore bytes until 0x0A, then pulse ovf_pulse, set len=0, go to COLLECT.
- HOLD: all rvld bytes are discarded and busy_drop is set; line_ack clears line_vld, busy_drop and len, then the FSM goes to COLLECT.
REQ-015 SHALL ignore byte 0x0D in every state.
REQ-016 SHALL treat byte 0x08 in COLLECT as backspace: len-- if len>0, otherwise no effect; it is never stored.
REQ-017 SHALL process an empty line (0x0A with len==0) as a valid line with line_len=0.
REQ-018 SHALL register rd_data with 1-cycle latency from rd_addr; it is valid only while line_vld=1.
REQ-019 SHALL hold line_len stable while line_vld=1.
REQ-020 SHALL ignore line_ack outside HOLD.
REQ-021 SHALL, when line_ack and rvld occur in the same cycle, apply line_ack first, so the byte is processed as the first byte in COLLECT.
REQ-022 SHALL never let len exceed DEPTH; every counter is sized so that no arithmetic wraps.

Reset
REQ-023 SHALL, on rst_n low, asynchronously set state=COLLECT and len=0, and set line_vld, ovf_pulse, busy_drop, rd_data, echo_tvld and echo_tdata to 0.
REQ-024 SHALL reset nothing in the buffer storage.
REQ-025 SHALL discard any partial line on reset mid-line; no ovf_pulse is issued.

Configuration
REQ-026 SHALL compile the echo path in only when macro UART_CMD_ECHO_EN is defined.
- With it: every byte accepted in COLLECT, including 0x0A and 0x08, is loaded into a 1-entry echo register. echo_tvld is high for exactly one cycle when the register is full and echo_trdy=1; the register then empties. If the register is still full when a new byte arrives, the new echo is lost; line capture is unaffected.
- Without it: the echo ports and logic are absent, and all other behaviour is identical.

Structure
REQ-027 SHALL place the FSM state enum and the character constants (LF 0x0A, CR 0x0D, BS 0x08) in shared package uart_cmd_pkg.
REQ-028 SHALL implement storage as sub-module uart_cmd_linebuf: DEPTHx8, 1 write port, 1 registered read port.

Verification
REQ-029 SHALL cover: rvld bytes "help\n" -> line_vld=1, line_len=4, rd_addr 0..3 read back 68,65,6C,70; line_ack -> line_vld=0 on the next cycle.
REQ-030 SHALL cover: 33 bytes 'a' then 0x0A with DEPTH=32 -> exactly one ovf_pulse, line_vld stays 0; a following "led\n" yields line_len=3.
REQ-031 SHALL cover: "ab" 0x08 "c\r\n" -> line_len=2, data 61,63.
REQ-032 SHALL cover: line held, then "x" sent -> busy_drop=1, line unchanged; line_ack and rvld 'z' in the same cycle -> next line starts with 'z'.
REQ-033 SHALL cover: rst_n low after "le" -> line_vld=0, line_len=0; then "on\n" gives line_len=2.
REQ-034 SHALL cover, with UART_CMD_ECHO_EN: "hi\n" with echo_trdy=1 -> three echo_tvld pulses carrying 68,69,0A in order.
